// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader : pops a synchronous FIFO in bursts onto a valid/ready stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_burst_reader #(
  parameter int BUF_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_fifo_rd_enb,
  input  logic [DATA_WIDTH-1:0] i_fifo_data_out,
  input  logic                  i_fifo_empty,
  input  logic [BUF_WIDTH:0]    i_fifo_count,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic [7:0]            o_bursts_done
);

  localparam int                c_timer_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_timer_w-1:0] c_timeout_m1 = c_timer_w'(TIMEOUT - 1);
  localparam logic [BUF_WIDTH:0] c_burst_len = (BUF_WIDTH + 1)'(BURST_LEN);
  localparam logic [BUF_WIDTH:0] c_one       = (BUF_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  logic [c_timer_w-1:0]   r_timer;
  logic [BUF_WIDTH:0]     r_pops_left;
  logic                   r_pend_valid;
  logic                   r_pend_last;
  logic [DATA_WIDTH-1:0]  r_mem [4];
  logic [3:0]             r_last;
  logic [1:0]             r_wr_ptr;
  logic [1:0]             r_rd_ptr;
  logic [2:0]             r_occ;
  logic [7:0]             r_bursts_done;

  logic w_below;
  logic w_nonzero;
  logic w_trigger;
  logic w_room;
  logic w_pop;
  logic w_take;

  assign w_below   = i_fifo_count < c_burst_len;
  assign w_nonzero = i_fifo_count != '0;
  assign w_trigger = (r_state == S_IDLE) &&
                     (!w_below || (w_nonzero && (r_timer == c_timeout_m1)));
  // The in-flight pop counts against the 4-entry buffer so its data always has a slot.
  assign w_room    = (r_occ + 3'(r_pend_valid)) < 3'd4;
  assign w_pop     = !rst && (r_state == S_BURST) && (r_pops_left != '0) &&
                     !i_fifo_empty && w_room;
  assign w_take    = o_m_valid && i_m_ready;

  assign o_fifo_rd_enb = w_pop;
  assign o_m_valid     = r_occ != 3'd0;
  assign o_m_data      = r_mem[r_rd_ptr];
  assign o_m_last      = r_last[r_rd_ptr];
  assign o_busy        = r_state != S_IDLE;
  assign o_bursts_done = r_bursts_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_pops_left   <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_last   <= 1'b0;
      r_mem         <= '{default: '0};
      r_last        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_occ         <= '0;
      r_bursts_done <= '0;
    end else begin
      r_pend_valid <= w_pop;
      r_pend_last  <= w_pop && (r_pops_left == c_one);

      if (r_pend_valid) begin
        r_mem[r_wr_ptr]  <= i_fifo_data_out;
        r_last[r_wr_ptr] <= r_pend_last;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_take) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_occ <= r_occ + 3'(r_pend_valid) - 3'(w_take);

      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_pops_left <= w_below ? i_fifo_count : c_burst_len;
            r_timer     <= '0;
            r_state     <= S_BURST;
          end else if (w_nonzero) begin
            r_timer <= r_timer + c_timer_w'(1);
          end else begin
            r_timer <= '0;
          end
        end
        S_BURST: begin
          if (w_pop) begin
            r_pops_left <= r_pops_left - c_one;
            if (r_pops_left == c_one) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((r_occ == 3'd0) && !r_pend_valid) begin
            r_bursts_done <= r_bursts_done + 8'd1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
